// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared opcodes, bus widths, FSM state and access-size decode for
//            the MIPS memory-access stage.
// Revision : 1.0
// ============================================================================
package mem_access_pkg;

    localparam int c_ALU_OP_W   = 8;
    localparam int c_REG_ADDR_W = 5;
    localparam logic c_RST_ENABLE = 1'b0;

    localparam logic [c_ALU_OP_W-1:0] c_EXE_LB_OP  = 8'b1110_0000;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_LH_OP  = 8'b1110_0001;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_LW_OP  = 8'b1110_0011;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_LBU_OP = 8'b1110_0100;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_LHU_OP = 8'b1110_0101;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_SB_OP  = 8'b1110_1000;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_SH_OP  = 8'b1110_1001;
    localparam logic [c_ALU_OP_W-1:0] c_EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } acc_size_t;

    function automatic acc_size_t op_size(input logic [c_ALU_OP_W-1:0] op);
        case (op)
            c_EXE_LB_OP, c_EXE_LBU_OP, c_EXE_SB_OP: op_size = SZ_BYTE;
            c_EXE_LH_OP, c_EXE_LHU_OP, c_EXE_SH_OP: op_size = SZ_HALF;
            c_EXE_LW_OP, c_EXE_SW_OP:               op_size = SZ_WORD;
            default:                                op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [c_ALU_OP_W-1:0] op);
        op_is_store = (op == c_EXE_SB_OP) || (op == c_EXE_SH_OP) || (op == c_EXE_SW_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Brief    : Byte/halfword lane selection and extension for loads, byte-enable
//            and lane-replicated data generation for stores.
// Revision : 1.0
// ============================================================================
module mem_align
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [c_ALU_OP_W-1:0] i_aluop,
    input  logic [1:0]            i_off,
    input  logic [31:0]           i_reg2,
    input  logic [31:0]           i_rdata,
    output logic [3:0]            o_sel,
    output logic [31:0]           o_wdata,
    output logic [31:0]           o_load_data
);

    logic [1:0]  w_byte_lane;
    logic        w_half_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Physical lane index counted from bits [7:0]; big-endian puts offset 0 on the top lane.
    assign w_byte_lane = BIG_ENDIAN ? ~i_off    : i_off;
    assign w_half_lane = BIG_ENDIAN ? ~i_off[1] : i_off[1];
    assign w_byte      = i_rdata[{w_byte_lane, 3'b000} +: 8];
    assign w_half      = i_rdata[{w_half_lane, 4'b0000} +: 16];

    always_comb begin
        o_sel       = 4'b1111;
        o_wdata     = i_reg2;
        o_load_data = i_rdata;
        case (i_aluop)
            c_EXE_LB_OP:  o_load_data = {{24{w_byte[7]}}, w_byte};
            c_EXE_LBU_OP: o_load_data = {24'h0, w_byte};
            c_EXE_LH_OP:  o_load_data = {{16{w_half[15]}}, w_half};
            c_EXE_LHU_OP: o_load_data = {16'h0, w_half};
            c_EXE_SB_OP: begin
                o_sel   = 4'b0001 << w_byte_lane;
                o_wdata = {4{i_reg2[7:0]}};
            end
            c_EXE_SH_OP: begin
                o_sel   = w_half_lane ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_reg2[15:0]}};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Brief    : MIPS memory-access stage: req/ack data bus FSM, alignment checks,
//            pipeline stall and the MEM/WB result register.
// Revision : 1.0
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [c_ALU_OP_W-1:0]   aluop_i,
    input  logic [31:0]             mem_addr_i,
    input  logic [31:0]             reg2_i,
    input  logic [c_REG_ADDR_W-1:0] wd_i,
    input  logic                    wreg_i,
    input  logic [31:0]             wdata_i,
    input  logic [31:0]             hi_i,
    input  logic [31:0]             lo_i,
    input  logic                    whilo_i,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [3:0]              mem_sel_o,
    output logic [31:0]             mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [31:0]             mem_rdata_i,
    output logic                    stall_o,
    output logic                    adel_o,
    output logic                    ades_o,
    output logic [c_REG_ADDR_W-1:0] wd_o,
    output logic                    wreg_o,
    output logic [31:0]             wdata_o,
    output logic [31:0]             hi_o,
    output logic [31:0]             lo_o,
    output logic                    whilo_o
);

    state_t      r_state, w_state_nxt;
    acc_size_t   w_size;
    logic        w_is_mem, w_is_store, w_is_load;
    logic        w_misaligned, w_mem_ok, w_req, w_stall;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata, w_load_data;

    assign w_size       = op_size(aluop_i);
    assign w_is_mem     = (w_size != SZ_NONE);
    assign w_is_store   = op_is_store(aluop_i);
    assign w_is_load    = w_is_mem & ~w_is_store;
    assign w_misaligned = ((w_size == SZ_HALF) & mem_addr_i[0]) |
                          ((w_size == SZ_WORD) & (|mem_addr_i[1:0]));
    assign w_mem_ok     = valid_i & w_is_mem & ~w_misaligned;

    // Gated by rst so the bus drops immediately on an asynchronous reset.
    assign w_req   = (rst != c_RST_ENABLE) &
                     (((r_state == ST_IDLE) & w_mem_ok) | (r_state == ST_WAIT));
    assign w_stall = w_req & ~mem_ack_i;

    mem_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_mem_align (
        .i_aluop     (aluop_i),
        .i_off       (mem_addr_i[1:0]),
        .i_reg2      (reg2_i),
        .i_rdata     (mem_rdata_i),
        .o_sel       (w_sel),
        .o_wdata     (w_wdata),
        .o_load_data (w_load_data)
    );

    assign mem_req_o   = w_req;
    assign mem_we_o    = w_req & w_is_store;
    assign mem_addr_o  = w_req ? {mem_addr_i[31:2], 2'b00} : 32'h0;
    assign mem_sel_o   = w_req ? w_sel   : 4'b0000;
    assign mem_wdata_o = w_req ? w_wdata : 32'h0;
    assign stall_o     = w_stall;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_mem_ok && !mem_ack_i) w_state_nxt = ST_WAIT;
            ST_WAIT: if (mem_ack_i)              w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ENABLE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ENABLE) begin
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= 32'h0;
            hi_o    <= 32'h0;
            lo_o    <= 32'h0;
            whilo_o <= 1'b0;
            adel_o  <= 1'b0;
            ades_o  <= 1'b0;
        end else if (w_stall || !valid_i) begin
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= 32'h0;
            hi_o    <= 32'h0;
            lo_o    <= 32'h0;
            whilo_o <= 1'b0;
            adel_o  <= 1'b0;
            ades_o  <= 1'b0;
        end else begin
            wd_o    <= wd_i;
            wreg_o  <= wreg_i & ~w_is_store & ~(w_is_load & w_misaligned);
            wdata_o <= w_is_load ? w_load_data : wdata_i;
            hi_o    <= hi_i;
            lo_o    <= lo_i;
            whilo_o <= whilo_i;
            adel_o  <= w_is_load & w_misaligned;
            ades_o  <= w_is_store & w_misaligned;
        end
    end

endmodule
`default_nettype wire
